event_timestamper: RTL
======================

# event_timestamper

Captures edges of a camera/strobe event line against the free-running frame-time binary counter and queues `{edge polarity, epoch, count}` timestamps for downstream consumption. Sits directly downstream of the timebase counter: it consumes the counter value and a rollover tick, and extends the count with an epoch register so long intervals stay unambiguous. Output is a small FIFO with a valid/ready handshake toward the host-side packetizer.

## Interface
- `NBITS`, 16: width of the counter value input.
- `EPOCH_BITS`, 8: width of the rollover epoch extension.
- `DEPTH_LOG2`, 3: log2 of the FIFO depth, which is 8 entries by default.
- `RISE_EN`, 1: record rising edges.
- `FALL_EN`, 0: record falling edges.

Ports:
- `clock`, input, 1: single clock for all logic.
- `reset`, input, 1: synchronous, active-high reset.
- `clear`, input, 1: synchronous flush of the FIFO, epoch and overflow; lower priority than `reset`.
- `event_in`, input, 1: raw event line.
- `count_in`, input, NBITS: current timebase counter value.
- `wrap_tick`, input, 1: high for exactly the cycle in which the counter advances from 2^NBITS−1 to 0.
- `ts_valid`, output, 1: FIFO non-empty.
- `ts_ready`, input, 1: consumer accepts the head entry.
- `ts_data`, output, NBITS+EPOCH_BITS+1: `{pol, epoch, count}`, where `pol` is 1 for a rising edge.
- `fifo_level`, output, DEPTH_LOG2+1: number of stored entries.
- `overflow`, output, 1: sticky flag, set when an edge is dropped.

## Operation
- **Edge detection:** `ev_r` samples the (optionally synchronized) event every clock; `ev_p` holds the previous `ev_r`.
  - Rising edge: `ev_r & ~ev_p`. Falling edge: `~ev_r & ev_p`.
  - An edge is recorded only if its polarity's enable parameter is 1.
- **Capture:** in the detection cycle, `{pol, epoch, count_in}` is pushed into the FIFO.
- **Epoch:** increments on each `wrap_tick` and wraps modulo 2^EPOCH_BITS silently.
  - An edge detected in the same cycle as `wrap_tick` captures the pre-increment epoch together with `count_in` (= MAX). The stamp is therefore consistent.
- **FIFO:** circular buffer with `DEPTH_LOG2`-bit pointers and a level counter. `ts_data` always shows the head entry, with no read latency.
  - Pop occurs when `ts_valid & ts_ready`.
  - Full with no pop: the push is dropped, `overflow` is set, and contents are unchanged.
  - Full with a pop in the same cycle: the push is accepted and `overflow` is not set.
  - Empty with a push: `ts_valid` rises the next cycle. There is no same-cycle bypass.
- **`clear`:** empties the FIFO, sets epoch to 0 and clears `overflow`. A push detected in the same cycle is discarded. `ev_r`/`ev_p` keep sampling, so edge detection continues uninterrupted.
- **Reset values:** `ts_valid` = 0, `fifo_level` = 0, `overflow` = 0, epoch = 0, pointers = 0, `ev_r` = `ev_p` = 0, synchronizer flops = 0, and `ts_data` = 0 (storage is cleared).
  - An `event_in` held high through reset release yields one rising edge after the pipeline fills.
- Reset mid-operation discards all queued stamps and any edge in flight.

## Timing
- Without sync: `event_in` sampled high at clock edge k → `ev_r` = 1 after k → push at edge k+1 with `count_in` as seen in cycle k..k+1 → `ts_valid` = 1 after edge k+1.
- With sync: add 2 cycles to the above.
- Minimum resolvable event pulse width: 1 cycle without sync; 1 cycle with sync, provided the pulse is sampled.
- Throughput: one push and one pop per cycle.
- `fifo_level` and `overflow` update at the same edge as the push/pop they reflect.

## Configuration
- `EVENT_TIMESTAMPER_SYNC_EN` defined: a 2-flop synchronizer precedes `ev_r`. Use for an asynchronous `event_in`; total latency is 4 edges.
- Not defined: `event_in` is taken directly into `ev_r` and must be synchronous to `clock`; latency is 2 edges.

## Test plan
- **Single rise:** `NBITS`=4, `EPOCH_BITS`=2, counter free-running, `event_in` rises while `count_in`=5 → `ts_data` = `{1, 2'd0, 4'd5}`, and `ts_valid` follows the latency above.
- **Wrap coincidence:** edge detected in the `wrap_tick` cycle (`count_in`=15) → stamp `{1, 0, 15}`. The next edge at `count_in`=2 → `{1, 1, 2}`.
- **Overflow:** `DEPTH_LOG2`=2, `ts_ready`=0, 5 rising edges → `fifo_level`=4 and `overflow`=1, and the 4 stored stamps are the first four.
  - Then assert `ts_ready`, and in the same cycle have `clear`=0 with one more edge while full → push accepted and level stays 4.
- **Both polarities:** `FALL_EN`=1, a 3-cycle pulse → two entries with `pol`=1 then `pol`=0, and the counts differ by 3.
- **Clear/reset mid-stream:** 3 entries queued, then `clear` → `fifo_level`=0, `ts_valid`=0, epoch=0 next cycle.
  - Reset with `event_in` held high → exactly one rising stamp after release.

Source files
------------

// File: rtl/event_timestamper_if.sv
// Timestamp output channel of event_timestamper: valid/ready handshake on the
// FIFO head plus the FIFO status flags.
// master: the timestamper (drives stamps and status); slave: the packetizer.
interface event_timestamper_if #(
  parameter int DATA_W = 25,
  parameter int LVL_W  = 4
);
  logic              ts_valid;
  logic              ts_ready;
  logic [DATA_W-1:0] ts_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;

  modport master (
    output ts_valid,
    output ts_data,
    output fifo_level,
    output overflow,
    input  ts_ready
  );

  modport slave (
    input  ts_valid,
    input  ts_data,
    input  fifo_level,
    input  overflow,
    output ts_ready
  );
endinterface

// File: rtl/event_timestamper.sv
// event_timestamper: stamps edges of event_in with {pol, epoch, count_in}.
// Queues the stamps in a small circular FIFO that always presents its head
// entry on the output channel.
// The epoch register extends the timebase count across counter rollovers.
// Optional feature: define EVENT_TIMESTAMPER_SYNC_EN to put a 2-flop
// synchronizer in front of the edge detector when event_in is asynchronous.
module event_timestamper #(
  parameter int NBITS      = 16,
  parameter int EPOCH_BITS = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int RISE_EN    = 1,
  parameter int FALL_EN    = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             event_in,
  input  logic [NBITS-1:0] count_in,
  input  logic             wrap_tick,
  event_timestamper_if.master ts
);

  localparam int DATA_W = NBITS + EPOCH_BITS + 1;
  localparam int LVL_W  = DEPTH_LOG2 + 1;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic                  ev_src;
  logic                  ev_r;
  logic                  ev_p;
  logic                  rise_det;
  logic                  fall_det;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  full;
  logic [EPOCH_BITS-1:0] epoch;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  ovf;

`ifdef EVENT_TIMESTAMPER_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  // Two-flop synchronizer for an asynchronous event line
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= event_in;
      sync_q2 <= sync_q1;
    end
  end

  assign ev_src = sync_q2;
`else
  assign ev_src = event_in;
`endif

  // Edge-detect pipeline; keeps sampling through clear
  always_ff @(posedge clock) begin
    if (reset) begin
      ev_r <= 1'b0;
      ev_p <= 1'b0;
    end else begin
      ev_r <= ev_src;
      ev_p <= ev_r;
    end
  end

  assign rise_det = (RISE_EN != 0) && ev_r && !ev_p;
  assign fall_det = (FALL_EN != 0) && !ev_r && ev_p;
  assign push_req = rise_det || fall_det;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign full    = (level == FULL_LEVEL);
  assign pop     = (level != '0) && ts.ts_ready;
  assign push_ok = push_req && (!full || pop);

  // Stamp storage; cleared on reset so the idle head reads as zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clear && push_ok) begin
      mem[wr_ptr] <= {rise_det, epoch, count_in};
    end
  end

  // Pointers, level, sticky overflow and rollover epoch
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      epoch  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (push_req && !push_ok) begin
        ovf <= 1'b1;
      end
      // A stamp taken in the wrap cycle uses the pre-increment epoch,
      // which matches count_in == MAX in that cycle.
      if (wrap_tick) begin
        epoch <= epoch + EPOCH_BITS'(1);
      end
    end
  end

  assign ts.ts_valid   = (level != '0);
  assign ts.ts_data    = mem[rd_ptr];
  assign ts.fifo_level = level;
  assign ts.overflow   = ovf;

endmodule
